// File: rtl/posit_defines_param.sv
// rtl/posit_defines_param.sv - shared width derivations and state encoding for the posit quire path
// Purpose: derives fraction/scale/quire widths from NBITS, ES and CBITS, and
// holds the accumulator state enum. No ports.
package posit_defines_param;

    function automatic int calc_fbits(input int nbits, input int es);
        return nbits - 3 - es;
    endfunction

    function automatic int calc_smax(input int nbits, input int es);
        return (nbits - 2) << es;
    endfunction

    // Two extra bits: one for the sign, one so that +SMAX and -SMAX both fit.
    function automatic int calc_sbits(input int nbits, input int es);
        return $clog2(calc_smax(nbits, es)) + 2;
    endfunction

    function automatic int calc_qbits(input int nbits, input int es, input int cbits);
        return 2 * calc_smax(nbits, es) + calc_fbits(nbits, es) + 2 + cbits;
    endfunction

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/posit_lzc.sv
// rtl/posit_lzc.sv - combinational leading-one detector
// Purpose: reports the index of the most significant set bit of data_i.
// Ports:
//   data_i  in  WIDTH  word to scan
//   pos_o   out PW     index of the leading one (0 when data_i is zero)
//   zero_o  out 1      data_i is all zeros
module posit_lzc #(
    parameter int WIDTH = 78,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [PW-1:0]    pos_o,
    output logic             zero_o
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        pos_o  = '0;
        zero_o = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                pos_o  = PW'(i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/posit_quire_accum.sv
// rtl/posit_quire_accum.sv - exact quire accumulation of decoded posit frames with normalised output
// Purpose: sums a framed stream of decoded posit values (sign/scale/fraction)
// into a two's-complement fixed-point quire, then on the frame's last element
// normalises the quire back to decoded form (truncated, unclamped scale).
// Ports:
//   clk, reset_n                          clock, synchronous active-low reset
//   in_valid/in_ready                     element handshake
//   in_sign/in_scale/in_fraction          decoded element value
//   in_zero/in_inf/in_last                element is zero / NaR / last of frame
//   out_valid/out_ready                   result handshake
//   out_sign/out_scale/out_fraction       decoded result value
//   out_zero/out_inf/out_inexact          result exactly zero / NaR / truncated
module posit_quire_accum
    import posit_defines_param::*;
#(
    parameter int NBITS = 16,
    parameter int ES    = 1,
    parameter int CBITS = 8,
    parameter int FBITS = calc_fbits(NBITS, ES),
    parameter int SMAX  = calc_smax(NBITS, ES),
    parameter int SBITS = calc_sbits(NBITS, ES),
    parameter int QBITS = calc_qbits(NBITS, ES, CBITS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [SBITS-1:0] in_scale,
    input  logic [FBITS-1:0]        in_fraction,
    input  logic                    in_zero,
    input  logic                    in_inf,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic signed [SBITS-1:0] out_scale,
    output logic [FBITS-1:0]        out_fraction,
    output logic                    out_zero,
    output logic                    out_inf,
    output logic                    out_inexact
);

    localparam int PW = $clog2(QBITS);

    typedef struct packed {
        logic                    sign;
        logic signed [SBITS-1:0] scale;
        logic [FBITS-1:0]        fraction;
        logic                    inf;
        logic                    zero;
    } value_t;

    state_e           state_q;
    logic [QBITS-1:0] quire_q;
    logic             inf_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    value_t           res_q;
    logic             inexact_q;

    // Element alignment: bit 0 of the quire weighs 2^(-SMAX-FBITS).
    logic [QBITS-1:0] mant;
    logic [SBITS:0]   shamt;
    logic [QBITS-1:0] aligned;
    logic [QBITS-1:0] addend;
    logic [QBITS-1:0] sum;
    logic             ovf_add;

    always_comb begin
        mant    = QBITS'({1'b1, in_fraction});
        shamt   = {in_scale[SBITS-1], in_scale} + (SBITS+1)'(SMAX);
        aligned = mant << shamt;
        addend  = in_sign ? -aligned : aligned;
        sum     = quire_q + addend;
        // Same-sign operands producing a result of the other sign.
        ovf_add = (addend[QBITS-1] == quire_q[QBITS-1]) && (sum[QBITS-1] != quire_q[QBITS-1]);
    end

    // Normalisation of the quire magnitude.
    logic [QBITS-1:0] mag;
    logic [PW-1:0]    lead_pos;
    logic             mag_zero;
    logic [PW-1:0]    norm_shift;
    logic [QBITS-2:0] normed;
    logic             norm_inexact;
    logic             res_inf;
    value_t           norm_d;

    assign mag = quire_q[QBITS-1] ? -quire_q : quire_q;

    posit_lzc #(
        .WIDTH(QBITS),
        .PW   (PW)
    ) u_lzc (
        .data_i(mag),
        .pos_o (lead_pos),
        .zero_o(mag_zero)
    );

    always_comb begin
        // Move the leading one to the top so the fraction is always the next
        // FBITS bits, with zero fill arriving naturally when the one is low.
        norm_shift   = PW'(QBITS - 1) - lead_pos;
        normed       = (QBITS-1)'(mag << norm_shift);
        norm_inexact = |normed[QBITS-2-FBITS:0];
        res_inf      = inf_q | ovf_q;

        norm_d          = '0;
        norm_d.inf      = res_inf;
        norm_d.zero     = mag_zero & ~res_inf;
        if (!res_inf && !mag_zero) begin
            norm_d.sign     = quire_q[QBITS-1];
            norm_d.scale    = SBITS'(int'(lead_pos) - SMAX - FBITS);
            norm_d.fraction = normed[QBITS-2 -: FBITS];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ACC;
            quire_q     <= '0;
            inf_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            inexact_q   <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (in_valid && in_ready_q) begin
                        if (in_inf) begin
                            inf_q <= 1'b1;
                        end else if (!in_zero) begin
                            quire_q <= sum;
                            if (ovf_add) begin
                                ovf_q <= 1'b1;
                            end
                        end
                        if (in_last) begin
                            state_q    <= NORM;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    res_q       <= norm_d;
                    inexact_q   <= norm_inexact;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        quire_q     <= '0;
                        inf_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                        state_q     <= ACC;
                    end
                end
                default: begin
                    state_q <= ACC;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sign     = res_q.sign;
    assign out_scale    = res_q.scale;
    assign out_fraction = res_q.fraction;
    assign out_zero     = res_q.zero;
    assign out_inf      = res_q.inf;
    assign out_inexact  = inexact_q;

endmodule

// File: tb/tb_posit_quire_accum.sv
// tb/tb_posit_quire_accum.sv - self-checking bench for posit_quire_accum
module tb_posit_quire_accum;

    localparam int FBITS = 12;
    localparam int SMAX  = 28;
    localparam int SBITS = 7;
    localparam int LSB_EXP = SMAX + FBITS;
    localparam logic signed [127:0] QMAX = (128'sd1 <<< 77) - 128'sd1;
    localparam logic signed [127:0] QMIN = -(128'sd1 <<< 77);

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic signed [SBITS-1:0] in_scale;
    logic [FBITS-1:0]        in_fraction;
    logic                    in_zero;
    logic                    in_inf;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sign;
    logic signed [SBITS-1:0] out_scale;
    logic [FBITS-1:0]        out_fraction;
    logic                    out_zero;
    logic                    out_inf;
    logic                    out_inexact;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [127:0] m_sum;
    bit                  m_inf;
    bit                  m_ovf;

    always #5 clk = ~clk;

    posit_quire_accum dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_scale    (in_scale),
        .in_fraction (in_fraction),
        .in_zero     (in_zero),
        .in_inf      (in_inf),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_scale   (out_scale),
        .out_fraction(out_fraction),
        .out_zero    (out_zero),
        .out_inf     (out_inf),
        .out_inexact (out_inexact)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic model_clear();
        m_sum = '0;
        m_inf = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Exact value of the element in units of 2^-(SMAX+FBITS).
    task automatic model_add(input bit s, input int sc, input int fr, input bit z, input bit inf);
        logic signed [127:0] t;
        if (inf) begin
            m_inf = 1'b1;
        end else if (!z) begin
            t = 128'(4096 + fr) << (sc + SMAX);
            if (s) t = -t;
            m_sum = m_sum + t;
            if (m_sum > QMAX || m_sum < QMIN) m_ovf = 1'b1;
        end
    endtask

    task automatic drive(input bit s, input int sc, input int fr, input bit z, input bit inf, input bit last);
        in_valid    = 1'b1;
        in_sign     = s;
        in_scale    = SBITS'(sc);
        in_fraction = FBITS'(fr);
        in_zero     = z;
        in_inf      = inf;
        in_last     = last;
    endtask

    task automatic send(input bit s, input int sc, input int fr, input bit z, input bit inf, input bit last);
        int g = 0;
        drive(s, sc, fr, z, inf, last);
        while (in_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) timeout_fail("send_wait");
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_add(s, sc, fr, z, inf);
    endtask

    task automatic check_fields(input string tag, input int exp_wait);
        int                  g = 0;
        int                  p = -1;
        logic [127:0]        mag;
        bit                  e_inf, e_zero, e_sign, e_inexact;
        logic [SBITS-1:0]    e_scale;
        logic [FBITS-1:0]    e_frac;
        while (out_valid !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) timeout_fail({tag, ".wait"});
        if (exp_wait >= 0) chk({tag, ".latency"}, 128'(g), 128'(exp_wait));

        mag = (m_sum < 0) ? -m_sum : m_sum;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        e_inf = m_inf | m_ovf;
        e_zero = 1'b0; e_sign = 1'b0; e_inexact = 1'b0; e_scale = '0; e_frac = '0;
        if (!e_inf) begin
            if (p < 0) begin
                e_zero = 1'b1;
            end else begin
                e_sign  = (m_sum < 0);
                e_scale = SBITS'(p - LSB_EXP);
                if (p >= FBITS) begin
                    e_frac    = FBITS'(mag >> (p - FBITS));
                    e_inexact = (mag & ((128'd1 << (p - FBITS)) - 128'd1)) != 0;
                end else begin
                    e_frac = FBITS'(mag << (FBITS - p));
                end
            end
        end
        chk({tag, ".inf"}, 128'(out_inf), 128'(e_inf));
        chk({tag, ".zero"}, 128'(out_zero), 128'(e_zero));
        chk({tag, ".sign"}, 128'(out_sign), 128'(e_sign));
        chk({tag, ".scale"}, 128'($unsigned(out_scale)), 128'(e_scale));
        chk({tag, ".fraction"}, 128'(out_fraction), 128'(e_frac));
        if (!e_inf) chk({tag, ".inexact"}, 128'(out_inexact), 128'(e_inexact));
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".in_ready_after"}, 128'(in_ready), 128'(1));
        chk({tag, ".out_valid_after"}, 128'(out_valid), 128'(0));
        model_clear();
    endtask

    task automatic check_result(input string tag, input int exp_wait);
        check_fields(tag, exp_wait);
        accept(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0; in_sign = 1'b0; in_scale = '0; in_fraction = '0;
        in_zero   = 1'b0; in_inf = 1'b0; in_last = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 128'(in_ready), 128'(1));
        chk("rst.out_valid", 128'(out_valid), 128'(0));
        chk("rst.out_inf", 128'(out_inf), 128'(0));
        chk("rst.out_zero", 128'(out_zero), 128'(0));
        chk("rst.out_scale", 128'($unsigned(out_scale)), 128'(0));
        chk("rst.out_fraction", 128'(out_fraction), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // 1.0 + 1.0 = 2.0, with latency check
        send(0, 0, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 1);
        chk("two_ones.in_ready_norm", 128'(in_ready), 128'(0));
        chk("two_ones.out_valid_early", 128'(out_valid), 128'(0));
        check_result("two_ones", 1);

        // +1.5 - 1.5 cancels exactly
        send(0, 0, 'h800, 0, 0, 0);
        send(1, 0, 'h800, 0, 0, 1);
        check_result("cancel", 1);

        // NaR poisons the frame, next frame is clean
        send(0, 0, 0, 0, 0, 0);
        send(0, 0, 0, 0, 1, 0);
        send(0, 1, 0, 0, 0, 1);
        check_result("nar", -1);
        send(0, 0, 0, 0, 0, 1);
        check_result("after_nar", -1);

        // quire extremes
        send(0, -28, 1, 0, 0, 1);
        check_result("min_scale", -1);
        send(0, 28, 0, 0, 0, 0);
        send(0, -28, 0, 0, 0, 1);
        check_result("wide_span", -1);

        // zero element closing a frame, all-zero frame, negative result
        send(0, 2, 0, 0, 0, 0);
        send(0, 0, 0, 1, 0, 1);
        check_result("zero_last", -1);
        send(0, 5, 7, 1, 0, 0);
        send(1, -3, 9, 1, 0, 1);
        check_result("all_zero", -1);
        send(1, 3, 'h555, 0, 0, 1);
        check_result("negative", -1);

        // backpressure: element offered while the result waits must be held
        send(0, 1, 'h123, 0, 0, 1);
        check_fields("bp", -1);
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_fields($sformatf("bp_hold%0d", k), -1);
            chk($sformatf("bp_hold%0d.in_ready", k), 128'(in_ready), 128'(0));
        end
        accept("bp");
        model_add(0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp_next", 1);

        // quire overflow at the largest magnitude
        for (int i = 0; i < 300; i++) send(0, 28, 'hFFF, 0, 0, (i == 299));
        check_result("overflow", -1);
        send(0, 0, 0, 0, 0, 1);
        check_result("after_ovf", -1);

        // randomised frames
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(6, 1);
            for (int e = 0; e < n; e++) begin
                send($urandom_range(1), int'($urandom_range(56)) - 28, $urandom_range(4095),
                     ($urandom_range(7) == 0), ($urandom_range(19) == 0), (e == n - 1));
            end
            check_result($sformatf("rand%0d", f), 1);
        end

        // reset mid-frame discards the partial sum
        send(0, 10, 'h3AB, 0, 0, 0);
        send(1, 4, 'h111, 0, 0, 0);
        send(0, 20, 'hFFF, 0, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_rst.in_ready", 128'(in_ready), 128'(1));
        chk("mid_rst.out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst.out_sign", 128'(out_sign), 128'(0));
        chk("mid_rst.out_fraction", 128'(out_fraction), 128'(0));
        model_clear();
        send(0, 0, 0, 0, 0, 1);
        check_result("after_rst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
